xm_tx_arbiter: RTL and testbench
================================

XM_TX_ARBITER -- requirements
Module: xm_tx_arbiter

Interface
REQ-001 SHALL take parameter NUM_SRC, default 4: number of AXIS TX requesters sharing one MAC lane.
REQ-002 SHALL take parameter DATA_W, default 32: beat data width.
REQ-003 SHALL take parameter VLDB_W, default 2: valid-byte field width.
REQ-004 SHALL take parameter ID_FIFO_DEPTH, default 8 (power of 2): number of outstanding unanswered packets.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports named as the codebase does: tx_user_clk_i and tx_user_rst_i.
REQ-006 SHALL have port tx_user_clk_i  in  1  lane TX user clock; sole clock.
REQ-007 SHALL have port tx_user_rst_i  in  1  async active-high reset.
REQ-008 SHALL have port link_up_i  in  1  lane link status, synchronous to tx_user_clk_i.
REQ-009 SHALL have ports s_tx_data_i  in  NUM_SRC*DATA_W, and s_tx_vldb_i  in  NUM_SRC*VLDB_W: per-source beat data and valid-byte field.
REQ-010 SHALL have ports s_tx_valid_i/s_tx_last_i/s_tx_user_i  in  NUM_SRC, and s_tx_ready_o  out  NUM_SRC: per-source AXIS handshake.
REQ-011 SHALL have ports s_tx_status_o, s_tx_rsp_valid_o  out  NUM_SRC: per-source routed transmit response.
REQ-012 SHALL have ports m_tx_data_o  out  DATA_W, m_tx_vldb_o  out  VLDB_W, m_tx_valid_o/m_tx_last_o/m_tx_user_o  out  1, m_tx_ready_i  in  1: MAC-side AXIS TX.
REQ-013 SHALL have ports m_tx_status_i, m_tx_rsp_valid_i  in  1: MAC-side transmit response, one per packet, in packet order.
REQ-014 SHALL have port rsp_orphan_o  out  1: sticky flag, response received with no outstanding packet.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and PKT.
REQ-016 In IDLE, grant SHALL occur only when link_up_i=1, the ID FIFO is not full, and any s_tx_valid_i bit is set.
REQ-017 On grant, winner = first valid source at or after rr_ptr, wrapping modulo NUM_SRC. Winner index SHALL be registered and pushed into the ID FIFO. FSM SHALL go to PKT.
REQ-018 In PKT, m_tx_* SHALL mux the granted source combinationally from the registered grant. s_tx_ready_o[g] = m_tx_ready_i. All other s_tx_ready_o bits SHALL be 0.
REQ-019 When m_tx_valid_o & m_tx_ready_i & m_tx_last_o, FSM SHALL return to IDLE and rr_ptr SHALL become (g+1) mod NUM_SRC.
REQ-020 Latency: the first beat SHALL appear on m_tx_valid_o in the cycle after the granting IDLE cycle. Consecutive packets SHALL be separated by exactly one IDLE cycle minimum.
REQ-021 In IDLE, m_tx_valid_o SHALL be 0 and all s_tx_ready_o SHALL be 0.
REQ-022 Deassertion of link_up_i during PKT SHALL NOT truncate the packet; only new grants are blocked.
REQ-023 On m_tx_rsp_valid_i with FIFO non-empty: pop head id; one cycle later, pulse s_tx_rsp_valid_o[id] for one cycle with s_tx_status_o[id] = the registered status; all other bits 0.
REQ-024 On m_tx_rsp_valid_i with FIFO empty: no pop, no pulse; set rsp_orphan_o (cleared only by reset).
REQ-025 A simultaneous push and pop SHALL both take effect. Occupancy SHALL be clog2(ID_FIFO_DEPTH)+1 bits, with pointers wrapping modulo depth.

Reset
REQ-026 On tx_user_rst_i, asynchronously: FSM=IDLE, rr_ptr=0, grant=0, FIFO empty, rsp_orphan_o=0, all s_tx_ready_o/s_tx_rsp_valid_o/s_tx_status_o=0, m_tx_valid_o=0.
REQ-027 Reset mid-packet SHALL abandon the packet without completing it; no response is forwarded for it.

Configuration
REQ-028 Macro XM_TX_ARB_PRIO_EN defined: in IDLE, source 0 SHALL win whenever valid; the remaining sources are round-robin from rr_ptr.
REQ-029 Macro XM_TX_ARB_PRIO_EN undefined: pure round-robin over all sources per REQ-017.

Structure
REQ-030 The shared package xm_tx_arb_pkg SHALL hold the FSM state typedef and the width localparams for the source id and FIFO occupancy.
REQ-031 Sub-module xm_id_fifo SHALL be the synchronous ID FIFO, with push, pop, full, empty, and head outputs.

Verification
REQ-032 Scenario: sources 0 and 2 each send a 3-beat packet at t0, link up -> order src0 then src2, one IDLE cycle between them, rr_ptr ends at 3.
REQ-033 Scenario: m_tx_ready_i toggles every cycle during a 4-beat packet -> data is unchanged and unduplicated, and only the granted s_tx_ready_o follows m_tx_ready_i.
REQ-034 Scenario: 8 packets sent with no responses, then a 9th packet is valid -> no grant until one m_tx_rsp_valid_i arrives; the responses then reach the correct sources in order.
REQ-035 Scenario: m_tx_rsp_valid_i with status=1 while the FIFO is empty -> no s_tx_rsp_valid_o pulse and rsp_orphan_o=1.
REQ-036 Scenario: link_up_i drops on beat 2 of a 5-beat packet -> all 5 beats are sent, and there is no further grant until link_up_i=1.
REQ-037 Scenario: with XM_TX_ARB_PRIO_EN defined, and sources 0, 1, 3 continuously valid -> src0 wins at every packet boundary.

Source files
------------

// File: rtl/xm_tx_arb_pkg.sv
// Shared types and width helpers for the XM TX arbiter and its ID FIFO.
// Optional source-0 priority is selected in the top by XM_TX_ARB_PRIO_EN.
package xm_tx_arb_pkg;

   typedef logic [0:0] arb_state_t;

   localparam arb_state_t ST_IDLE = 1'b0;
   localparam arb_state_t ST_PKT  = 1'b1;

   localparam int XM_NUM_SRC_DEF    = 4;
   localparam int XM_FIFO_DEPTH_DEF = 8;

   function automatic int src_id_w(input int num_src);
      return (num_src > 1) ? $clog2(num_src) : 1;
   endfunction

   function automatic int fifo_occ_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int XM_SRC_ID_W_DEF = src_id_w(XM_NUM_SRC_DEF);
   localparam int XM_OCC_W_DEF    = fifo_occ_w(XM_FIFO_DEPTH_DEF);

endpackage

// File: rtl/xm_id_fifo.sv
// Synchronous FIFO of granted source ids, one entry per packet awaiting its
// MAC response. Push and pop in the same cycle both take effect.
module xm_id_fifo
   import xm_tx_arb_pkg::*;
#(
   parameter int DEPTH = XM_FIFO_DEPTH_DEF,
   parameter int W     = XM_SRC_ID_W_DEF,
   parameter int OCC_W = XM_OCC_W_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic [W-1:0] push_id_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (occ_q == OCC_W'(DEPTH));
   assign empty_o = (occ_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_id_i;
      end
   end

endmodule

// File: rtl/xm_tx_arbiter.sv
// Round-robin arbiter sharing one MAC TX lane among NUM_SRC AXIS sources and
// routing in-order MAC responses back. XM_TX_ARB_PRIO_EN gives source 0 priority.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no packet in flight; may grant a new source
// ST_PKT  | granted source streams to the MAC until its last beat
module xm_tx_arbiter
   import xm_tx_arb_pkg::*;
#(
   parameter int NUM_SRC       = 4,
   parameter int DATA_W        = 32,
   parameter int VLDB_W        = 2,
   parameter int ID_FIFO_DEPTH = 8
) (
   input  logic                      tx_user_clk_i,
   input  logic                      tx_user_rst_i,
   input  logic                      link_up_i,
   input  logic [NUM_SRC*DATA_W-1:0] s_tx_data_i,
   input  logic [NUM_SRC*VLDB_W-1:0] s_tx_vldb_i,
   input  logic [NUM_SRC-1:0]        s_tx_valid_i,
   input  logic [NUM_SRC-1:0]        s_tx_last_i,
   input  logic [NUM_SRC-1:0]        s_tx_user_i,
   output logic [NUM_SRC-1:0]        s_tx_ready_o,
   output logic [NUM_SRC-1:0]        s_tx_status_o,
   output logic [NUM_SRC-1:0]        s_tx_rsp_valid_o,
   output logic [DATA_W-1:0]         m_tx_data_o,
   output logic [VLDB_W-1:0]         m_tx_vldb_o,
   output logic                      m_tx_valid_o,
   output logic                      m_tx_last_o,
   output logic                      m_tx_user_o,
   input  logic                      m_tx_ready_i,
   input  logic                      m_tx_status_i,
   input  logic                      m_tx_rsp_valid_i,
   output logic                      rsp_orphan_o
);

   localparam int ID_W  = src_id_w(NUM_SRC);
   localparam int OCC_W = fifo_occ_w(ID_FIFO_DEPTH);

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [NUM_SRC-1:0]  rsp_valid_q, rsp_valid_d;
   logic [NUM_SRC-1:0]  rsp_status_q, rsp_status_d;
   logic                orphan_q, orphan_d;

   logic [DATA_W-1:0]   src_data [NUM_SRC];
   logic [VLDB_W-1:0]   src_vldb [NUM_SRC];
   logic                win_found;
   logic [ID_W-1:0]     win_idx;
   logic                grant_en;
   logic                pkt_done;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   logic [ID_W-1:0]     fifo_head;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign src_data[g] = s_tx_data_i[g*DATA_W +: DATA_W];
      assign src_vldb[g] = s_tx_vldb_i[g*VLDB_W +: VLDB_W];
   end

   always_comb begin : arb
      int              cand;
      logic [ID_W-1:0] cand_id;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_id   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand    = (int'(rr_ptr_q) + k) % NUM_SRC;
         cand_id = ID_W'(cand);
         if (!win_found && s_tx_valid_i[cand_id]) begin
            win_found = 1'b1;
            win_idx   = cand_id;
         end
      end
`ifdef XM_TX_ARB_PRIO_EN
      if (s_tx_valid_i[0]) begin
         win_found = 1'b1;
         win_idx   = '0;
      end
`endif
   end

   // Outputs follow the registered grant so the first beat lands one cycle after the grant.
   assign m_tx_data_o  = src_data[grant_q];
   assign m_tx_vldb_o  = src_vldb[grant_q];
   assign m_tx_last_o  = s_tx_last_i[grant_q];
   assign m_tx_user_o  = s_tx_user_i[grant_q];
   assign m_tx_valid_o = (state_q == ST_PKT) & s_tx_valid_i[grant_q];

   always_comb begin
      s_tx_ready_o = '0;
      if (state_q == ST_PKT) begin
         s_tx_ready_o[grant_q] = m_tx_ready_i;
      end
   end

   assign pkt_done = m_tx_valid_o & m_tx_ready_i & m_tx_last_o;
   assign grant_en = (state_q == ST_IDLE) & link_up_i & ~fifo_full & win_found;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_en) begin
               grant_d = win_idx;
               state_d = ST_PKT;
            end
         end
         ST_PKT: begin
            if (pkt_done) begin
               rr_ptr_d = ID_W'((int'(grant_q) + 1) % NUM_SRC);
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign fifo_pop = m_tx_rsp_valid_i & ~fifo_empty;

   always_comb begin
      rsp_valid_d  = '0;
      rsp_status_d = '0;
      orphan_d     = orphan_q;
      if (fifo_pop) begin
         rsp_valid_d[fifo_head]  = 1'b1;
         rsp_status_d[fifo_head] = m_tx_status_i;
      end else if (m_tx_rsp_valid_i) begin
         orphan_d = 1'b1;
      end
   end

   always_ff @(posedge tx_user_clk_i or posedge tx_user_rst_i) begin
      if (tx_user_rst_i) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         rsp_valid_q  <= '0;
         rsp_status_q <= '0;
         orphan_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_status_q <= rsp_status_d;
         orphan_q     <= orphan_d;
      end
   end

   assign s_tx_rsp_valid_o = rsp_valid_q;
   assign s_tx_status_o    = rsp_status_q;
   assign rsp_orphan_o     = orphan_q;

   xm_id_fifo #(
      .DEPTH (ID_FIFO_DEPTH),
      .W     (ID_W),
      .OCC_W (OCC_W)
   ) u_id_fifo (
      .clk_i     (tx_user_clk_i),
      .rst_i     (tx_user_rst_i),
      .push_i    (grant_en),
      .push_id_i (win_idx),
      .pop_i     (fifo_pop),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .head_o    (fifo_head)
   );

endmodule

// File: tb/tb_xm_tx_arbiter.sv
// Directed bench for xm_tx_arbiter: a packet-source model drives the four
// requesters and every accepted MAC beat is logged against hand-built vectors.
module tb_xm_tx_arbiter;

   logic         clk;
   logic         tx_rst;
   logic         link_up;
   logic [127:0] s_tx_data_i;
   logic [7:0]   s_tx_vldb_i;
   logic [3:0]   s_tx_valid_i;
   logic [3:0]   s_tx_last_i;
   logic [3:0]   s_tx_user_i;
   logic [3:0]   s_tx_ready_o;
   logic [3:0]   s_tx_status_o;
   logic [3:0]   s_tx_rsp_valid_o;
   logic [31:0]  m_tx_data_o;
   logic [1:0]   m_tx_vldb_o;
   logic         m_tx_valid_o;
   logic         m_tx_last_o;
   logic         m_tx_user_o;
   logic         m_tx_ready_i;
   logic         m_tx_status_i;
   logic         m_tx_rsp_valid_i;
   logic         rsp_orphan_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int npk  [4];
   int plen [4];
   int beat [4];
   int pkt  [4];

   logic [35:0] log_q [$];
   int          log_c [$];

   logic [3:0] smp_ready;
   logic [3:0] smp_rsp_v;
   logic [3:0] smp_rsp_s;
   logic       smp_orphan;
   logic       ready_mon;
   logic       toggle_rdy;
   int         rdy_cnt;
   int         t0;
   int         ord3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int         rsp3 [8] = '{1, 2, 3, 0, 1, 2, 3, 2};

   xm_tx_arbiter dut (
      .tx_user_clk_i    (clk),
      .tx_user_rst_i    (tx_rst),
      .link_up_i        (link_up),
      .s_tx_data_i      (s_tx_data_i),
      .s_tx_vldb_i      (s_tx_vldb_i),
      .s_tx_valid_i     (s_tx_valid_i),
      .s_tx_last_i      (s_tx_last_i),
      .s_tx_user_i      (s_tx_user_i),
      .s_tx_ready_o     (s_tx_ready_o),
      .s_tx_status_o    (s_tx_status_o),
      .s_tx_rsp_valid_o (s_tx_rsp_valid_o),
      .m_tx_data_o      (m_tx_data_o),
      .m_tx_vldb_o      (m_tx_vldb_o),
      .m_tx_valid_o     (m_tx_valid_o),
      .m_tx_last_o      (m_tx_last_o),
      .m_tx_user_o      (m_tx_user_o),
      .m_tx_ready_i     (m_tx_ready_i),
      .m_tx_status_i    (m_tx_status_i),
      .m_tx_rsp_valid_i (m_tx_rsp_valid_i),
      .rsp_orphan_o     (rsp_orphan_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

   // Beat encoding: {user=src[0], vldb=beat[1:0], last, src, pkt, beat}
   function automatic logic [35:0] mk(int s, int p, int b, int len);
      logic [31:0] d;
      d = {8'(s), 8'(p), 16'(b)};
      return {1'(s), 2'(b), (b == len - 1), d};
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      logic [35:0] e;
      for (int s = 0; s < 4; s++) begin
         e = mk(s, pkt[s], beat[s], plen[s]);
         s_tx_valid_i[s]          = (npk[s] > 0);
         s_tx_data_i[s*32 +: 32]  = e[31:0];
         s_tx_last_i[s]           = e[32];
         s_tx_vldb_i[s*2 +: 2]    = e[34:33];
         s_tx_user_i[s]           = e[35];
      end
   endtask

   task automatic add_pkts(int s, int n, int len);
      npk[s]  = n;
      plen[s] = len;
      drive();
   endtask

   task automatic tick();
      @(negedge clk);
      smp_ready  = s_tx_ready_o;
      smp_rsp_v  = s_tx_rsp_valid_o;
      smp_rsp_s  = s_tx_status_o;
      smp_orphan = rsp_orphan_o;
      if (m_tx_valid_o && m_tx_ready_i) begin
         log_q.push_back({m_tx_user_o, m_tx_vldb_o, m_tx_last_o, m_tx_data_o});
         log_c.push_back(cyc);
      end
      if (ready_mon) begin
         check("ready_other_bits", 64'(smp_ready & 4'b1101), 0);
         check("ready_follow", 64'(smp_ready[1] & ~m_tx_ready_i), 0);
         if (smp_ready[1]) rdy_cnt++;
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) begin
         if (s_tx_valid_i[s] && smp_ready[s]) begin
            if (beat[s] == plen[s] - 1) begin
               beat[s] = 0;
               pkt[s]  = pkt[s] + 1;
               npk[s]  = npk[s] - 1;
            end else begin
               beat[s] = beat[s] + 1;
            end
         end
      end
      if (toggle_rdy) m_tx_ready_i = ~m_tx_ready_i;
      drive();
   endtask

   task automatic run_until(int n, int budget, string tag);
      int t;
      t = 0;
      while (log_q.size() < n && t < budget) begin
         tick();
         t++;
      end
      check(tag, 64'(log_q.size()), 64'(n));
   endtask

   task automatic send_rsp(logic st, int exp_src);
      logic [3:0] expv;
      expv = (exp_src < 0) ? 4'b0000 : 4'(1 << exp_src);
      m_tx_rsp_valid_i = 1'b1;
      m_tx_status_i    = st;
      tick();
      m_tx_rsp_valid_i = 1'b0;
      m_tx_status_i    = 1'b0;
      tick();
      check("rsp_pulse", 64'(smp_rsp_v), 64'(expv));
      check("rsp_status", 64'(smp_rsp_s), st ? 64'(expv) : 64'(0));
      tick();
      check("rsp_one_cycle", 64'(smp_rsp_v), 0);
   endtask

   task automatic do_reset();
      tx_rst = 1'b1;
      for (int s = 0; s < 4; s++) begin
         npk[s]  = 0;
         plen[s] = 1;
         beat[s] = 0;
         pkt[s]  = 0;
      end
      log_q.delete();
      log_c.delete();
      link_up          = 1'b1;
      m_tx_ready_i     = 1'b1;
      m_tx_rsp_valid_i = 1'b0;
      m_tx_status_i    = 1'b0;
      ready_mon        = 1'b0;
      toggle_rdy       = 1'b0;
      drive();
      repeat (2) @(posedge clk);
      #1;
      tx_rst = 1'b0;
   endtask

   initial begin
      ready_mon        = 1'b0;
      toggle_rdy       = 1'b0;
      rdy_cnt          = 0;
      smp_ready        = '0;
      tx_rst           = 1'b1;
      link_up          = 1'b1;
      m_tx_ready_i     = 1'b1;
      m_tx_rsp_valid_i = 1'b0;
      m_tx_status_i    = 1'b0;
      for (int s = 0; s < 4; s++) begin
         npk[s] = 0; plen[s] = 1; beat[s] = 0; pkt[s] = 0;
      end
      drive();

      @(negedge clk);
      check("rst_m_valid", 64'(m_tx_valid_o), 0);
      check("rst_s_ready", 64'(s_tx_ready_o), 0);
      check("rst_rsp_valid", 64'(s_tx_rsp_valid_o), 0);
      check("rst_status", 64'(s_tx_status_o), 0);
      check("rst_orphan", 64'(rsp_orphan_o), 0);
      do_reset();

      // Sources 0 and 2 together: order, latency, one-cycle gap, rr_ptr wrap to 3.
      t0 = cyc;
      add_pkts(0, 1, 3);
      add_pkts(2, 1, 3);
      run_until(6, 40, "s1_beat_count");
      for (int i = 0; i < 3; i++) begin
         check("s1_src0_beat", 64'(log_q[i]), 64'(mk(0, 0, i, 3)));
         check("s1_src2_beat", 64'(log_q[3+i]), 64'(mk(2, 0, i, 3)));
      end
      check("s1_first_latency", 64'(log_c[0]), 64'(t0 + 1));
      check("s1_idle_gap", 64'(log_c[3] - log_c[2]), 2);
      add_pkts(1, 1, 1);
      add_pkts(3, 1, 1);
      run_until(8, 30, "s1_rr_count");
      check("s1_rr_src3_first", 64'(log_q[6]), 64'(mk(3, 0, 0, 1)));
      check("s1_rr_src1_next", 64'(log_q[7]), 64'(mk(1, 0, 0, 1)));

      // Backpressure toggling every cycle during a 4-beat packet.
      do_reset();
      rdy_cnt    = 0;
      ready_mon  = 1'b1;
      toggle_rdy = 1'b1;
      add_pkts(1, 1, 4);
      run_until(4, 40, "s2_beat_count");
      ready_mon  = 1'b0;
      toggle_rdy = 1'b0;
      m_tx_ready_i = 1'b1;
      repeat (4) tick();
      check("s2_no_dup", 64'(log_q.size()), 4);
      for (int i = 0; i < 4; i++) check("s2_beat", 64'(log_q[i]), 64'(mk(1, 0, i, 4)));
      check("s2_ready_handshakes", 64'(rdy_cnt), 4);

      // ID FIFO full after 8 unanswered packets blocks the 9th grant.
      do_reset();
      add_pkts(0, 2, 1);
      add_pkts(1, 2, 1);
      add_pkts(2, 3, 1);
      add_pkts(3, 2, 1);
      run_until(8, 60, "s3_eight_pkts");
      repeat (10) tick();
      check("s3_blocked_when_full", 64'(log_q.size()), 8);
      for (int i = 0; i < 8; i++) check("s3_order", 64'(log_q[i]), 64'(mk(ord3[i], i / 4, 0, 1)));
      send_rsp(1'b1, 0);
      run_until(9, 10, "s3_ninth_granted");
      check("s3_ninth_pkt", 64'(log_q[8]), 64'(mk(2, 2, 0, 1)));
      for (int i = 0; i < 8; i++) send_rsp(1'(i % 2), rsp3[i]);
      check("s3_no_orphan", 64'(smp_orphan), 0);

      // Reset mid-packet abandons it; a later response is an orphan.
      do_reset();
      add_pkts(1, 1, 4);
      run_until(2, 20, "s4_partial");
      tx_rst = 1'b1;
      @(negedge clk);
      check("s4_rst_m_valid", 64'(m_tx_valid_o), 0);
      check("s4_rst_s_ready", 64'(s_tx_ready_o), 0);
      do_reset();
      tick();
      check("s4_orphan_clear", 64'(smp_orphan), 0);
      send_rsp(1'b1, -1);
      check("s4_orphan_set", 64'(smp_orphan), 1);
      repeat (3) tick();
      check("s4_orphan_sticky", 64'(smp_orphan), 1);
      check("s4_nothing_sent", 64'(log_q.size()), 0);

      // Link drop during beat 2 of 5 completes the packet but blocks the next grant.
      do_reset();
      add_pkts(3, 1, 5);
      run_until(1, 10, "s5_first_beat");
      link_up = 1'b0;
      add_pkts(1, 1, 1);
      run_until(5, 30, "s5_all_beats");
      check("s5_beat2", 64'(log_q[1]), 64'(mk(3, 0, 1, 5)));
      check("s5_last_beat", 64'(log_q[4]), 64'(mk(3, 0, 4, 5)));
      repeat (10) tick();
      check("s5_no_grant_link_down", 64'(log_q.size()), 5);
      link_up = 1'b1;
      run_until(6, 10, "s5_grant_after_link");
      check("s5_src1_pkt", 64'(log_q[5]), 64'(mk(1, 0, 0, 1)));

      // Sources 0, 1, 3 continuously valid with 2-beat packets.
      do_reset();
      add_pkts(0, 3, 2);
      add_pkts(1, 3, 2);
      add_pkts(3, 3, 2);
      run_until(8, 40, "s6_four_pkts");
`ifdef XM_TX_ARB_PRIO_EN
      check("s6_prio_p0", 64'(log_q[0][31:24]), 0);
      check("s6_prio_p1", 64'(log_q[2][31:24]), 0);
      check("s6_prio_p2", 64'(log_q[4][31:24]), 0);
      check("s6_prio_p3", 64'(log_q[6][31:24]), 1);
`else
      check("s6_rr_p0", 64'(log_q[0][31:24]), 0);
      check("s6_rr_p1", 64'(log_q[2][31:24]), 1);
      check("s6_rr_p2", 64'(log_q[4][31:24]), 3);
      check("s6_rr_p3", 64'(log_q[6][31:24]), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
